// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/pause/clear FSM with MM:SS.CC BCD count; optional lap freeze under `STOPWATCH_LAP_EN.
// Latency: key pulse or tick to state/display change is 1 clk edge; rst_n clears asynchronously.
// Backpressure: none; every key and tick pulse is consumed in the cycle it arrives.
module stopwatch_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_ps_en,
    input  logic       key_rst_en,
    input  logic       tick_en,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec,
    output logic [7:0] disp_cs,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap_pulse
);

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
        logic [3:0] cs_t;
        logic [3:0] cs_u;
    } bcd_time_t;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    logic [1:0] state_q;
    logic [1:0] state_nxt;
    bcd_time_t  cnt_q;
    bcd_time_t  cnt_nxt;
    bcd_time_t  cnt_inc;
    bcd_time_t  disp_sel;
    logic [6:0] carry;
    logic       wrap_q;
    logic       wrap_nxt;
    logic       count_en;

`ifdef STOPWATCH_LAP_EN
    logic       lap_q;
    logic       lap_nxt;
    logic       snap_cap;
    bcd_time_t  snap_q;
`endif

    // One BCD digit step: returns {carry_out, digit}. Out-of-range digits fold to 0.
    function automatic logic [4:0] digit_step(input logic [3:0] d, input logic [3:0] lim,
                                              input logic cin);
        if (!cin)
            return {1'b0, d};
        else if (d >= lim)
            return {1'b1, 4'd0};
        else
            return {1'b0, d + 4'd1};
    endfunction

    always_comb begin
        cnt_inc  = cnt_q;
        carry    = '0;
        carry[0] = 1'b1;
        {carry[1], cnt_inc.cs_u}  = digit_step(cnt_q.cs_u,  4'd9, carry[0]);
        {carry[2], cnt_inc.cs_t}  = digit_step(cnt_q.cs_t,  4'd9, carry[1]);
        {carry[3], cnt_inc.sec_u} = digit_step(cnt_q.sec_u, 4'd9, carry[2]);
        {carry[4], cnt_inc.sec_t} = digit_step(cnt_q.sec_t, 4'd5, carry[3]);
        {carry[5], cnt_inc.min_u} = digit_step(cnt_q.min_u, 4'd9, carry[4]);
        {carry[6], cnt_inc.min_t} = digit_step(cnt_q.min_t, 4'd5, carry[5]);
    end

    // The tick is judged on the pre-transition state, so a tick with ps in RUN still counts.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        wrap_nxt  = 1'b0;
        count_en  = (state_q == ST_RUN) && tick_en;
`ifdef STOPWATCH_LAP_EN
        lap_nxt   = lap_q;
        snap_cap  = 1'b0;
`endif
        if (count_en) begin
            cnt_nxt  = cnt_inc;
            wrap_nxt = carry[6];
        end
        case (state_q)
            ST_IDLE: begin
                if (key_rst_en)
                    cnt_nxt = '0;
                else if (key_ps_en)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (key_ps_en) begin
                    state_nxt = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                    lap_nxt   = 1'b0;
                end else if (key_rst_en) begin
                    snap_cap  = !lap_q;
                    lap_nxt   = !lap_q;
`endif
                end
            end
            ST_PAUSE: begin
                if (key_rst_en) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (key_ps_en) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
`ifdef STOPWATCH_LAP_EN
        if (state_nxt == ST_IDLE)
            lap_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Snapshot takes the pre-increment count so the frozen value matches the press instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q  <= 1'b0;
            snap_q <= '0;
        end else begin
            lap_q <= lap_nxt;
            if (snap_cap)
                snap_q <= cnt_q;
        end
    end

    always_comb begin
        disp_sel = lap_q ? snap_q : cnt_q;
    end

    assign lap_hold = lap_q;
`else
    always_comb begin
        disp_sel = cnt_q;
    end

    assign lap_hold = 1'b0;
`endif

    assign disp_min   = {disp_sel.min_t, disp_sel.min_u};
    assign disp_sec   = {disp_sel.sec_t, disp_sel.sec_u};
    assign disp_cs    = {disp_sel.cs_t,  disp_sel.cs_u};
    assign running    = (state_q == ST_RUN);
    assign wrap_pulse = wrap_q;

endmodule
